avalon_telemetre_us_multi: RTL and testbench
============================================

# avalon_telemetre_us_multi

Multi-channel ultrasonic rangefinder controller; generalises the single-sensor telemetre to `N_CH` HC-SR04-style sensors, scanned round-robin by one shared ping engine. It sits on the Qsys Avalon-MM bus beside the servomoteur and seven-segment peripherals, so the Nios can sweep the radar while reading distances per channel. Each sensor raises its own timeout flag, and the channel-0 distance is still exported on a conduit for direct display.

## Interface
- `N_CH`, 4: number of sensors, 1..8.
- `DIST_W`, 10: distance width in cm; results saturate at 2^DIST_W-1.
- `CLK_FREQ_HZ`, 50_000_000: clock frequency; derives `CYC_PER_US` = CLK_FREQ_HZ/1e6 and `CYC_PER_CM` = 58*CYC_PER_US.
- `TRIG_US`, 10: trigger pulse width.
- `TIMEOUT_US`, 30000: maximum wait for the echo rise, and maximum echo high time.
- `HOLDOFF_US`, 60000: gap after each ping before the next channel.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `address` in 4: Avalon word address.
- `read` in 1: Avalon read strobe.
- `write` in 1: Avalon write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data; read latency 1, no waitrequest.
- `trig` out N_CH: per-sensor trigger.
- `echo` in N_CH: per-sensor echo; asynchronous.
- `dist_cm` out DIST_W: latest channel-0 result.
- `irq` out 1: level interrupt; high while `STATUS.done` is set and `CTRL.irq_en` is set.

## Operation
Register map (word addresses):
- 0 CTRL, R/W, reset 0:
  - bit0 `run`: continuous scan.
  - bit1 `start`: single scan; self-clearing and reads 0.
  - bit2 `irq_en`.
  - bits[15:8] `mask`: channel enables; bits at or above N_CH are ignored.
- 1 STATUS:
  - bit0 `busy`.
  - bit1 `done`: set at the end of each full scan; write 1 to clear.
  - bits[6:4] current channel.
  - bits[23:16] per-channel timeout flags, read-only.
- 2+c DIST[c], read-only: bits[DIST_W-1:0] distance, bit31 `valid`.
- Reads of unmapped addresses return 0.

FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE:
  - Leaves when `run`=1 or `start` is pending, and `mask`≠0.
  - Selects the lowest enabled channel; the pending `start` is consumed.
  - `mask`=0 keeps the block in IDLE and does not set `done`.
- TRIG: `trig[c]`=1 for TRIG_US*CYC_PER_US cycles, then WAIT_RISE.
- WAIT_RISE:
  - Synchronised echo rise → MEASURE; distance counter and prescaler cleared.
  - Timeout → result all-ones, timeout flag[c]=1, valid=1, then HOLDOFF.
- MEASURE:
  - Prescaler counts to CYC_PER_CM-1, then increments the distance counter, which saturates.
  - Echo fall → DIST[c] written with the counter, timeout flag[c]=0, valid=1, then HOLDOFF.
  - Echo high for TIMEOUT → handled as a WAIT_RISE timeout.
- HOLDOFF:
  - Waits HOLDOFF_US.
  - Then moves to the next enabled channel above c, wrapping around.
  - On wrap, or when c was the highest enabled channel, `done`=1.
  - After that, continue if `run`=1, otherwise IDLE.
- `mask` is sampled only when a channel is chosen. A mask change mid-ping finishes the current channel.
- Clearing `run` mid-scan finishes the current ping, including HOLDOFF, then goes to IDLE.
- Simultaneous `done` set and software write-1-clear: set wins.
- Only the active channel is observed; other echo inputs are ignored.

## Timing
- Reset values:
  - `trig`=0 immediately, asynchronously.
  - `readdata`=0, `dist_cm`=0, `irq`=0.
  - All DIST registers = 0 with valid=0; all timeout flags = 0; FSM in IDLE.
- Echo passes a 2-flop synchroniser plus an edge register, giving 3 cycles of input latency.
- DIST[c] and `dist_cm` update 1 cycle after the fall is detected.
- `trig` rises 1 cycle after leaving IDLE or HOLDOFF.
- `readdata` is valid the cycle after `read`.
- A write takes effect on the next cycle.

## Structure
- Package `telemetre_us_pkg`:
  - Register address constants.
  - CTRL/STATUS bit positions.
  - FSM state enum.
  - Helper function to convert µs to cycles.
- Sub-module `us_echo_sync`: per-bit 2-flop synchroniser with rise/fall pulse outputs, instantiated N_CH wide.
- Top: FSM, ping timers, prescaler, register file.

## Test plan
Bench parameters: CLK_FREQ_HZ=1_000_000, so CYC_PER_CM=58. TIMEOUT_US=2000, HOLDOFF_US=100, N_CH=4.
- Single shot, mask=0x01, echo high 580 cycles → `trig[0]` high exactly 10 cycles; DIST[0]=10, valid=1; `done`=1; `dist_cm`=10; `irq`=1 only with `irq_en` set.
- `run`=1, mask=0x0A, echo widths 116 and 290 cycles → pings alternate ch1, ch3, ch1, …; DIST[1]=2, DIST[3]=5; `trig[0]` and `trig[2]` never pulse.
- No echo on ch2 → after 2000 cycles DIST[2]=0x3FF and timeout flag bit18=1; a later 58-cycle echo gives DIST[2]=1 and clears the flag.
- DIST_W=6, echo 5800 cycles with TIMEOUT_US=10000 → result saturates at 63.
- Clear `run` during MEASURE on ch0 → ping completes, then IDLE, `busy`=0. A separate run with mask=0 → block stays IDLE, `done` stays 0.
- Assert `reset_n` low during TRIG → `trig` drops in the same cycle, all registers read 0. After release the block is idle until a new `start`.

Source files
------------

// File: rtl/telemetre_us_pkg.sv
// Shared definitions for the multi-channel ultrasonic rangefinder.
// Contents: Avalon word addresses, CTRL/STATUS bit positions,
// ping-engine FSM state encoding and a microsecond-to-cycle helper.
package telemetre_us_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_DIST0  = 4'd2;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_MASK_LSB = 8;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_CH_LSB = 4;
  localparam int ST_TO_LSB = 16;

  localparam int DIST_VALID = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLDOFF
  } state_t;

  function automatic int us_to_cycles(input int us, input int clk_hz);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/us_echo_sync.sv
// Echo input conditioning: per-bit 2-flop synchroniser followed by an
// edge register. rise/fall are single-cycle pulses, 3 cycles after the pin.
// Ports: clk, rst_n (async active-low), din[W] (asynchronous echo pins),
//        rise[W], fall[W] (synchronous edge pulses).
module us_echo_sync
  import telemetre_us_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s_p0, s_p1, s_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0 <= '0;
      s_p1 <= '0;
      s_p2 <= '0;
    end else begin
      // p0/p1: metastability chain, p2: previous level for edge detect
      s_p0 <= din;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign rise = s_p1 & ~s_p2;
  assign fall = ~s_p1 & s_p2;

endmodule

// File: rtl/avalon_telemetre_us_multi.sv
// Multi-channel HC-SR04 style rangefinder on Avalon-MM. One shared ping
// engine scans the enabled sensors round-robin; each result lands in its
// own DIST register, channel 0 is also mirrored on dist_cm.
// Ports: clk, reset_n (async active-low), Avalon slave (address, read,
//        write, writedata, readdata, latency 1), trig[N_CH] out,
//        echo[N_CH] in (async), dist_cm out, irq out (level).
module avalon_telemetre_us_multi
  import telemetre_us_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIST_W      = 10,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30000,
  parameter int HOLDOFF_US  = 60000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [N_CH-1:0]   trig,
  input  logic [N_CH-1:0]   echo,
  output logic [DIST_W-1:0] dist_cm,
  output logic              irq
);

  localparam int          CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int          CYC_PER_CM = 58 * CYC_PER_US;
  localparam int          PRE_W      = $clog2(CYC_PER_CM);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_CM - 1);
  localparam logic [31:0] TRIG_LAST  = 32'(us_to_cycles(TRIG_US, CLK_FREQ_HZ) - 1);
  localparam logic [31:0] TO_LAST    = 32'(us_to_cycles(TIMEOUT_US, CLK_FREQ_HZ) - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(us_to_cycles(HOLDOFF_US, CLK_FREQ_HZ) - 1);

  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == '1) ? v : v + DIST_W'(1);
  endfunction

  // {found, index} of the lowest enabled channel whose index is >= lo
  function automatic logic [3:0] pick_ch(input logic [N_CH-1:0] m, input logic [3:0] lo);
    logic [3:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [31:0]         tmr_q;
  logic [PRE_W-1:0]    pre_q;
  logic [DIST_W-1:0]   cnt_q, cnt_step, res_val;
  logic                run_q, irq_en_q, start_q, oneshot_q, oneshot_d, done_q;
  logic [N_CH-1:0]     mask_q, valid_q, to_q;
  logic [DIST_W-1:0]   dist_q [N_CH];
  logic [N_CH-1:0]     echo_rise, echo_fall;
  logic                rise_c, fall_c;
  logic                tmr_clr, meas_clr, res_wr, res_to, done_set, start_take;
  logic [3:0]          first, nxt;
  logic [31:0]         rd_mux;
  logic                unused_wd;

  assign unused_wd = ^writedata;

  us_echo_sync #(.W(N_CH)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (echo),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  // Only the active channel's edges reach the FSM
  always_comb begin
    rise_c = 1'b0;
    fall_c = 1'b0;
    trig   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (3'(i) == ch_q) begin
        rise_c  = echo_rise[i];
        fall_c  = echo_fall[i];
        trig[i] = (state_q == S_TRIG);
      end
    end
  end

  // Result of a fall includes the current cycle's prescaler step
  assign cnt_step = (pre_q == PRE_LAST) ? sat_inc(cnt_q) : cnt_q;
  assign res_val  = res_to ? '1 : cnt_step;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    oneshot_d  = oneshot_q;
    tmr_clr    = 1'b0;
    meas_clr   = 1'b0;
    res_wr     = 1'b0;
    res_to     = 1'b0;
    done_set   = 1'b0;
    start_take = 1'b0;
    first      = pick_ch(mask_q, 4'd0);
    nxt        = pick_ch(mask_q, {1'b0, ch_q} + 4'd1);
    unique case (state_q)
      S_IDLE: begin
        if ((run_q || start_q) && first[3]) begin
          state_d    = S_TRIG;
          ch_d       = first[2:0];
          tmr_clr    = 1'b1;
          start_take = start_q;
          oneshot_d  = start_q;
        end
      end
      S_TRIG: begin
        if (tmr_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          tmr_clr = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (rise_c) begin
          state_d  = S_MEASURE;
          tmr_clr  = 1'b1;
          meas_clr = 1'b1;
        end else if (tmr_q == TO_LAST) begin
          state_d = S_HOLDOFF;
          tmr_clr = 1'b1;
          res_wr  = 1'b1;
          res_to  = 1'b1;
        end
      end
      S_MEASURE: begin
        if (fall_c || (tmr_q == TO_LAST)) begin
          state_d = S_HOLDOFF;
          tmr_clr = 1'b1;
          res_wr  = 1'b1;
          res_to  = !fall_c;
        end
      end
      S_HOLDOFF: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_clr = 1'b1;
          if (nxt[3] && (run_q || oneshot_q)) begin
            state_d = S_TRIG;
            ch_d    = nxt[2:0];
          end else begin
            // no higher channel means the scan wrapped
            done_set  = !nxt[3];
            oneshot_d = 1'b0;
            if (!nxt[3] && run_q && first[3]) begin
              state_d = S_TRIG;
              ch_d    = first[2:0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    tmr_q <= tmr_clr ? '0 : tmr_q + 32'd1;
    if (meas_clr) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_MEASURE) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      cnt_q <= cnt_step;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (address == ADDR_CTRL) begin
      rd_mux[CTRL_RUN]                  = run_q;
      rd_mux[CTRL_IRQ_EN]               = irq_en_q;
      rd_mux[CTRL_MASK_LSB +: N_CH]     = mask_q;
    end else if (address == ADDR_STATUS) begin
      rd_mux[ST_BUSY]                   = (state_q != S_IDLE);
      rd_mux[ST_DONE]                   = done_q;
      rd_mux[ST_CH_LSB +: 3]            = ch_q;
      rd_mux[ST_TO_LSB +: N_CH]         = to_q;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (address == 4'(ADDR_DIST0 + 4'(i))) begin
          rd_mux[DIST_W-1:0] = dist_q[i];
          rd_mux[DIST_VALID] = valid_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      oneshot_q <= 1'b0;
      run_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      start_q   <= 1'b0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      valid_q   <= '0;
      to_q      <= '0;
      dist_cm   <= '0;
      readdata  <= '0;
      for (int i = 0; i < N_CH; i++) dist_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      oneshot_q <= oneshot_d;
      if (start_take) start_q <= 1'b0;
      if (write && address == ADDR_CTRL) begin
        run_q    <= writedata[CTRL_RUN];
        irq_en_q <= writedata[CTRL_IRQ_EN];
        mask_q   <= writedata[CTRL_MASK_LSB +: N_CH];
        if (writedata[CTRL_START]) start_q <= 1'b1;
      end
      // a scan completing in the same cycle as a clear keeps done set
      if (done_set) done_q <= 1'b1;
      else if (write && address == ADDR_STATUS && writedata[ST_DONE]) done_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (res_wr && 3'(i) == ch_q) begin
          dist_q[i]  <= res_val;
          valid_q[i] <= 1'b1;
          to_q[i]    <= res_to;
        end
      end
      if (res_wr && ch_q == 3'd0) dist_cm <= res_val;
      readdata <= read ? rd_mux : '0;
    end
  end

  assign irq = done_q & irq_en_q;

endmodule

// File: tb/tb_avalon_telemetre_us_multi.sv
module tb_avalon_telemetre_us_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address, address_s;
  logic        read, write, read_s, write_s;
  logic [31:0] writedata, writedata_s, readdata, readdata_s;
  logic [3:0]  trig, echo, trig_s, echo_s;
  logic [9:0]  dist_cm;
  logic [5:0]  dist_cm_s;
  logic        irq, irq_s;

  int checks = 0;
  int errors = 0;

  int echo_w [4];
  int ecnt   [4];
  int tp_cnt [4];
  int thi    [4];
  int tlen   [4];
  int ping_q [$];
  logic [3:0] trig_prev;

  always #5 clk = ~clk;

  avalon_telemetre_us_multi #(
    .N_CH(4), .DIST_W(10), .CLK_FREQ_HZ(1_000_000), .TRIG_US(10),
    .TIMEOUT_US(2000), .HOLDOFF_US(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .trig(trig), .echo(echo),
    .dist_cm(dist_cm), .irq(irq)
  );

  avalon_telemetre_us_multi #(
    .N_CH(4), .DIST_W(6), .CLK_FREQ_HZ(1_000_000), .TRIG_US(10),
    .TIMEOUT_US(10000), .HOLDOFF_US(100)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .address(address_s), .read(read_s), .write(write_s),
    .writedata(writedata_s), .readdata(readdata_s), .trig(trig_s), .echo(echo_s),
    .dist_cm(dist_cm_s), .irq(irq_s)
  );

  // Sensor model: after each trigger pulse, wait 3 cycles, then echo high echo_w[c] cycles
  initial begin
    echo = '0;
    trig_prev = '0;
    for (int c = 0; c < 4; c++) begin
      ecnt[c] = 0; tp_cnt[c] = 0; thi[c] = 0; tlen[c] = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (trig[c]) thi[c]++;
        if (trig[c] && !trig_prev[c]) begin
          tp_cnt[c]++;
          ping_q.push_back(c);
        end
        if (!trig[c] && trig_prev[c]) begin
          tlen[c] = thi[c];
          thi[c] = 0;
          echo[c] = 1'b0;
          if (echo_w[c] > 0) ecnt[c] = echo_w[c] + 3;
        end else if (ecnt[c] > 0) begin
          ecnt[c]--;
          echo[c] = (ecnt[c] < echo_w[c]);
        end else begin
          echo[c] = 1'b0;
        end
      end
      trig_prev = trig;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input bit sel, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel) begin address_s = a; writedata_s = d; write_s = 1'b1; end
    else     begin address   = a; writedata   = d; write   = 1'b1; end
    @(negedge clk);
    write = 1'b0; write_s = 1'b0;
  endtask

  task automatic bus_read(input bit sel, input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    if (sel) begin address_s = a; read_s = 1'b1; end
    else     begin address   = a; read   = 1'b1; end
    @(negedge clk);
    read = 1'b0; read_s = 1'b0;
    d = sel ? readdata_s : readdata;
  endtask

  // Poll STATUS until bit 'pos' equals 'val'; an expired budget is a failed check
  task automatic poll_status(input bit sel, input int pos, input bit val, input int max_iter,
                             input string tag);
    logic [31:0] st;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_iter && !hit; i++) begin
      bus_read(sel, 4'd1, st);
      if (st[pos] == val) hit = 1'b1;
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int saved;
    bit seen;
    reset_n = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    address_s = '0; read_s = 1'b0; write_s = 1'b0; writedata_s = '0;
    echo_s = '0;
    for (int c = 0; c < 4; c++) echo_w[c] = 0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_trig", {28'd0, trig}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_dist_cm", {22'd0, dist_cm}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    bus_read(0, 4'd0, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(0, 4'd1, rd); check("rst_status", rd, 32'd0);
    bus_read(0, 4'd2, rd); check("rst_dist0", rd, 32'd0);
    bus_read(0, 4'd12, rd); check("unmapped", rd, 32'd0);

    // single shot on channel 0, 580-cycle echo -> 10 cm
    echo_w[0] = 580;
    bus_write(0, 4'd0, 32'h0000_0102);
    poll_status(0, 1, 1'b1, 2000, "t1_done");
    check("t1_trig_len", tlen[0], 32'd10);
    bus_read(0, 4'd2, rd); check("t1_dist0", rd, 32'h8000_000A);
    check("t1_dist_cm", {22'd0, dist_cm}, 32'd10);
    check("t1_irq_off", {31'd0, irq}, 32'd0);
    bus_read(0, 4'd1, rd); check("t1_status", rd, 32'h0000_0002);
    bus_write(0, 4'd0, 32'h0000_0104);
    check("t1_irq_on", {31'd0, irq}, 32'd1);
    bus_write(0, 4'd1, 32'h0000_0002);
    check("t1_irq_clr", {31'd0, irq}, 32'd0);
    bus_read(0, 4'd1, rd); check("t1_done_clr", rd, 32'd0);

    // continuous scan over channels 1 and 3
    bus_write(0, 4'd0, 32'h0000_0A00);
    for (int c = 0; c < 4; c++) tp_cnt[c] = 0;
    ping_q.delete();
    echo_w[1] = 116; echo_w[3] = 290;
    bus_write(0, 4'd0, 32'h0000_0A01);
    for (int i = 0; i < 4000 && ping_q.size() < 3; i++) @(negedge clk);
    bus_write(0, 4'd0, 32'h0000_0A00);
    poll_status(0, 0, 1'b0, 2000, "t2_idle");
    check("t2_npings", ping_q.size(), 32'd3);
    check("t2_order0", ping_q[0], 32'd1);
    check("t2_order1", ping_q[1], 32'd3);
    check("t2_order2", ping_q[2], 32'd1);
    check("t2_trig0_quiet", tp_cnt[0], 32'd0);
    check("t2_trig2_quiet", tp_cnt[2], 32'd0);
    bus_read(0, 4'd3, rd); check("t2_dist1", rd, 32'h8000_0002);
    bus_read(0, 4'd5, rd); check("t2_dist3", rd, 32'h8000_0005);

    // timeout on channel 2, then recovery
    bus_write(0, 4'd1, 32'h0000_0002);
    echo_w[2] = 0;
    bus_write(0, 4'd0, 32'h0000_0402);
    poll_status(0, 1, 1'b1, 3000, "t3_done_to");
    bus_read(0, 4'd4, rd); check("t3_dist2_to", rd, 32'h8000_03FF);
    bus_read(0, 4'd1, rd); check("t3_flags_set", (rd >> 16) & 32'hF, 32'h4);
    echo_w[2] = 58;
    bus_write(0, 4'd1, 32'h0000_0002);
    bus_write(0, 4'd0, 32'h0000_0402);
    poll_status(0, 1, 1'b1, 3000, "t3_done_ok");
    bus_read(0, 4'd4, rd); check("t3_dist2_ok", rd, 32'h8000_0001);
    bus_read(0, 4'd1, rd); check("t3_flags_clr", (rd >> 16) & 32'hF, 32'h0);

    // saturation with DIST_W=6: 5800-cycle echo -> 100 cm clamps to 63
    bus_write(1, 4'd0, 32'h0000_0102);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (trig_s[0]) seen = 1'b1;
    end
    check("t4_trig_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 100 && trig_s[0]; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    echo_s[0] = 1'b1;
    repeat (5800) @(negedge clk);
    echo_s[0] = 1'b0;
    poll_status(1, 1, 1'b1, 500, "t4_done");
    bus_read(1, 4'd2, rd); check("t4_dist_sat", rd, 32'h8000_003F);
    check("t4_dist_cm_sat", {26'd0, dist_cm_s}, 32'd63);

    // clear run mid-measure: ping completes then idle
    bus_write(0, 4'd1, 32'h0000_0002);
    echo_w[0] = 580;
    tp_cnt[0] = 0;
    bus_write(0, 4'd0, 32'h0000_0101);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (echo[0]) seen = 1'b1;
    end
    check("t5_echo_seen", {31'd0, seen}, 32'd1);
    repeat (20) @(negedge clk);
    bus_write(0, 4'd0, 32'h0000_0100);
    poll_status(0, 0, 1'b0, 1000, "t5_idle");
    check("t5_one_ping", tp_cnt[0], 32'd1);
    bus_read(0, 4'd2, rd); check("t5_dist0", rd, 32'h8000_000A);
    bus_write(0, 4'd1, 32'h0000_0002);
    bus_write(0, 4'd0, 32'h0000_0001);
    repeat (50) @(negedge clk);
    bus_read(0, 4'd1, rd); check("t5_mask0_status", rd, 32'd0);
    check("t5_mask0_trig", tp_cnt[0], 32'd1);
    bus_write(0, 4'd0, 32'h0000_0000);

    // reset asserted during TRIG
    bus_write(0, 4'd0, 32'h0000_0102);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (trig[0]) seen = 1'b1;
    end
    check("t6_trig_high", {31'd0, seen}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("t6_trig_async", {28'd0, trig}, 32'd0);
    repeat (2) @(negedge clk);
    check("t6_dist_cm", {22'd0, dist_cm}, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      bus_read(0, 4'(a), rd);
      check($sformatf("t6_reg%0d", a), rd, 32'd0);
    end
    saved = tp_cnt[0];
    repeat (100) @(negedge clk);
    check("t6_no_trig", tp_cnt[0], saved);
    bus_read(0, 4'd1, rd); check("t6_idle", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
